tmds_channel_encoder: RTL and testbench



---
 rtl/tmds_channel_encoder.sv | 157 +++++++++++++++
 tb/tb_tmds_channel_encoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_encoder.sv
// DVI/TMDS single-channel encoder: 8b/10b video coding with DC balance plus control tokens.
// Two register stages (q_m/popcount, then symbol/disparity). Optional TERC4 islands under TMDS_TERC4_EN.
`timescale 1ns/1ps
module tmds_channel_encoder #(
    parameter logic [9:0] RESET_TOKEN = 10'b1101010100
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       de,
    input  logic [1:0] c,
    input  logic [7:0] d,
`ifdef TMDS_TERC4_EN
    input  logic       island,
    input  logic [3:0] aux,
`endif
    output logic [9:0] q
);

    logic [3:0]        w_n1d;
    logic              w_use_xnor;
    logic [8:0]        w_qm;
    logic [3:0]        w_n1qm;

    logic              r_de;
    logic [1:0]        r_c;
    logic [8:0]        r_qm;
    logic [3:0]        r_n1;
    logic [3:0]        r_n0;
`ifdef TMDS_TERC4_EN
    logic              r_island;
    logic [3:0]        r_aux;
`endif

    logic [9:0]        r_q;
    logic signed [4:0] r_cnt;

    logic [9:0]        w_sym;
    logic signed [5:0] w_cnt_next;
    logic signed [5:0] w_cnt_ext;
    logic signed [5:0] w_n1s;
    logic signed [5:0] w_n0s;

    // Transition-minimising stage: pick XOR or XNOR chaining from the pixel's ones count.
    always_comb begin
        w_n1d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_n1d = w_n1d + {3'b000, d[i]};
        end
        w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !d[0]);
        w_qm    = 9'd0;
        w_qm[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ d[i]) : (w_qm[i-1] ^ d[i]);
        end
        w_qm[8] = ~w_use_xnor;
        w_n1qm  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_n1qm = w_n1qm + {3'b000, w_qm[i]};
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_de     <= 1'b0;
            r_c      <= 2'b00;
            r_qm     <= 9'd0;
            r_n1     <= 4'd0;
            r_n0     <= 4'd8;
`ifdef TMDS_TERC4_EN
            r_island <= 1'b0;
            r_aux    <= 4'd0;
`endif
        end else begin
            r_de     <= de;
            r_c      <= c;
            r_qm     <= w_qm;
            r_n1     <= w_n1qm;
            r_n0     <= 4'd8 - w_n1qm;
`ifdef TMDS_TERC4_EN
            r_island <= island;
            r_aux    <= aux;
`endif
        end
    end

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4(input logic [3:0] sel);
        logic [9:0] sym;
        case (sel)
            4'h0:    sym = 10'b1010011100;
            4'h1:    sym = 10'b1001100011;
            4'h2:    sym = 10'b1011100100;
            4'h3:    sym = 10'b1011100010;
            4'h4:    sym = 10'b0101110001;
            4'h5:    sym = 10'b0100011110;
            4'h6:    sym = 10'b0110001110;
            4'h7:    sym = 10'b0100111100;
            4'h8:    sym = 10'b1011001100;
            4'h9:    sym = 10'b0100111001;
            4'hA:    sym = 10'b0110011100;
            4'hB:    sym = 10'b1011000110;
            4'hC:    sym = 10'b1010001110;
            4'hD:    sym = 10'b1001110001;
            4'hE:    sym = 10'b0101100011;
            default: sym = 10'b1011000011;
        endcase
        return sym;
    endfunction
`endif

    assign w_cnt_ext = {r_cnt[4], r_cnt};
    assign w_n1s     = {2'b00, r_n1};
    assign w_n0s     = {2'b00, r_n0};

    // DC-balance stage: invert the data bits when that pulls the running disparity toward zero.
    always_comb begin
        w_sym      = 10'd0;
        w_cnt_next = 6'sd0;
`ifdef TMDS_TERC4_EN
        if (r_island) begin
            w_sym = terc4(r_aux);
        end else
`endif
        if (!r_de) begin
            case (r_c)
                2'b00:   w_sym = 10'b1101010100;
                2'b01:   w_sym = 10'b0010101011;
                2'b10:   w_sym = 10'b0101010100;
                default: w_sym = 10'b1010101011;
            endcase
        end else if ((r_cnt == 5'sd0) || (r_n1 == r_n0)) begin
            w_sym      = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_cnt_next = r_qm[8] ? (w_cnt_ext + (w_n1s - w_n0s))
                                 : (w_cnt_ext + (w_n0s - w_n1s));
        end else if (((r_cnt > 5'sd0) && (r_n1 > r_n0)) ||
                     ((r_cnt < 5'sd0) && (r_n0 > r_n1))) begin
            w_sym      = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_next = w_cnt_ext + {4'b0000, r_qm[8], 1'b0} + (w_n0s - w_n1s);
        end else begin
            w_sym      = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_next = w_cnt_ext - {4'b0000, ~r_qm[8], 1'b0} + (w_n1s - w_n0s);
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_q   <= RESET_TOKEN;
            r_cnt <= 5'sd0;
        end else begin
            r_q   <= w_sym;
            r_cnt <= w_cnt_next[4:0];
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Self-checking bench for tmds_channel_encoder: disparity-based reference model checked every cycle,
// decode round-trip on video symbols, and hand-computed literal symbols at chosen output edges.
`timescale 1ns/1ps
module tb_tmds_channel_encoder;

    localparam logic [9:0] RESET_TOKEN = 10'b1101010100;
    localparam logic [9:0] CTRL [4] = '{10'b1101010100, 10'b0010101011,
                                        10'b0101010100, 10'b1010101011};
    localparam logic [9:0] TERC [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       de    = 1'b0;
    logic [1:0] c     = 2'b00;
    logic [7:0] d     = 8'h00;
    logic       island = 1'b0;
    logic [3:0] aux    = 4'h0;
    logic [9:0] q;

    always #5 clkin = ~clkin;

    tmds_channel_encoder dut (
        .clkin  (clkin),
        .reset  (reset),
        .de     (de),
        .c      (c),
        .d      (d),
`ifdef TMDS_TERC4_EN
        .island (island),
        .aux    (aux),
`endif
        .q      (q)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // Reference model: inputs wait one edge in a pending slot, then become the next symbol.
    logic       exp_valid = 1'b0;
    logic [9:0] exp_q     = '0;
    logic       exp_video = 1'b0;
    logic [7:0] exp_d     = '0;
    int         m_cnt     = 0;
    logic       p_de = 1'b0, p_island = 1'b0;
    logic [1:0] p_c  = 2'b00;
    logic [7:0] p_d  = 8'h00;
    logic [3:0] p_aux = 4'h0;

    logic [9:0] lit_val [int];
    string      lit_name [int];

    // Send data bits as-is or inverted, whichever moves the running disparity toward zero.
    function automatic logic [9:0] enc_pixel(input logic [7:0] dd, input int cnt_in);
        int ones = $countones(dd);
        logic xn = (ones > 4) || (ones == 4 && dd[0] == 1'b0);
        logic [8:0] qm;
        int bal;
        logic inv;
        qm[0] = dd[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ dd[i]) : (qm[i-1] ^ dd[i]);
        qm[8] = ~xn;
        bal = 2 * $countones(qm[7:0]) - 8;
        if (cnt_in == 0 || bal == 0) inv = ~qm[8];
        else inv = ((cnt_in > 0) == (bal > 0));
        return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] sym);
        logic [7:0] data = sym[9] ? ~sym[7:0] : sym[7:0];
        logic [7:0] r;
        r[0] = data[0];
        for (int i = 1; i < 8; i++) r[i] = sym[8] ? (data[i] ^ data[i-1]) : ~(data[i] ^ data[i-1]);
        return r;
    endfunction

    always @(posedge clkin) begin
        edge_n = edge_n + 1;
        if (reset) begin
            exp_valid = 1'b1;
            exp_q     = RESET_TOKEN;
            exp_video = 1'b0;
            m_cnt     = 0;
            p_de = 1'b0; p_c = 2'b00; p_d = 8'h00; p_island = 1'b0; p_aux = 4'h0;
        end else if (exp_valid) begin
            exp_video = 1'b0;
`ifdef TMDS_TERC4_EN
            if (p_island) begin
                exp_q = TERC[p_aux];
                m_cnt = 0;
            end else
`endif
            if (!p_de) begin
                exp_q = CTRL[p_c];
                m_cnt = 0;
            end else begin
                exp_q     = enc_pixel(p_d, m_cnt);
                m_cnt     = m_cnt + 2 * $countones(exp_q) - 10;
                exp_video = 1'b1;
                exp_d     = p_d;
            end
            p_de = de; p_c = c; p_d = d; p_island = island; p_aux = aux;
        end
    end

    always @(negedge clkin) begin
        if (exp_valid) begin
            $display("edge %0d q=%b model=%b", edge_n, q, exp_q);
            n_cmp++;
            if (q !== exp_q) begin
                n_bad++;
                $display("FAIL model_q edge %0d: got %b need %b", edge_n, q, exp_q);
            end
            if (exp_video) begin
                n_cmp++;
                if (decode(q) !== exp_d) begin
                    n_bad++;
                    $display("FAIL decode edge %0d: got %h need %h", edge_n, decode(q), exp_d);
                end
            end
            if (lit_val.exists(edge_n)) begin
                n_cmp++;
                if (q !== lit_val[edge_n]) begin
                    n_bad++;
                    $display("FAIL %s edge %0d: got %b need %b",
                             lit_name[edge_n], edge_n, q, lit_val[edge_n]);
                end
                lit_val.delete(edge_n);
            end
        end
    end

    task automatic drive(input logic r, input logic e, input logic [1:0] cc, input logic [7:0] dd);
        @(negedge clkin);
        reset = r; de = e; c = cc; d = dd; island = 1'b0; aux = 4'h0;
    endtask

    task automatic drive_isl(input logic [3:0] a);
        @(negedge clkin);
        reset = 1'b0; de = 1'b0; c = 2'b00; d = 8'h00; island = 1'b1; aux = a;
    endtask

    // off=2: symbol of the inputs just driven; off=1: symbol produced at the very next edge.
    task automatic expect_at(input int off, input logic [9:0] v, input string nm);
        lit_val[edge_n + off]  = v;
        lit_name[edge_n + off] = nm;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 2'b00, 8'h00);
            expect_at(1, 10'b1101010100, "reset_hold");
        end
        drive(0, 0, 2'b00, 8'h00);
        expect_at(1, 10'b1101010100, "release_flush");
        expect_at(2, 10'b1101010100, "release_ctrl0");
        drive(0, 0, 2'b00, 8'h00);
        expect_at(2, 10'b1101010100, "ctrl00");
        drive(0, 0, 2'b01, 8'h00); expect_at(2, 10'b0010101011, "ctrl01");
        drive(0, 0, 2'b10, 8'h00); expect_at(2, 10'b0101010100, "ctrl10");
        drive(0, 0, 2'b11, 8'h00); expect_at(2, 10'b1010101011, "ctrl11");
        drive(0, 0, 2'b00, 8'h00);
        drive(0, 1, 2'b00, 8'h00); expect_at(2, 10'b0100000000, "zero_first");
        drive(0, 1, 2'b00, 8'h00); expect_at(2, 10'b1111111111, "zero_second");
        drive(0, 0, 2'b00, 8'h00);
        drive(0, 1, 2'b00, 8'hFF); expect_at(2, 10'b1000000000, "ff_from_ctrl");
        drive(0, 0, 2'b00, 8'h00);

        for (int i = 0; i < 64; i++) drive(0, 1, 2'b00, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 24; i++)
            drive(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));

        // Leave cnt at -8 before the reset so a stale disparity would change the restart symbol.
        drive(0, 0, 2'b00, 8'h00);
        drive(0, 1, 2'b00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 2'b00, 8'hA5);
            expect_at(2, 10'b0101100011, "a5_stream");
        end
        drive(1, 1, 2'b00, 8'hA5); expect_at(1, 10'b1101010100, "midreset_edge");
        drive(0, 1, 2'b00, 8'h00);
        expect_at(1, 10'b1101010100, "midreset_flush");
        expect_at(2, 10'b0100000000, "resume_cnt0");
        drive(0, 1, 2'b00, 8'hA5); expect_at(2, 10'b0101100011, "resume_a5");
        drive(0, 1, 2'b00, 8'hA5);

`ifdef TMDS_TERC4_EN
        drive(0, 1, 2'b00, 8'h00);
        for (int a = 0; a < 16; a++) begin
            drive_isl(4'(a));
            expect_at(2, TERC[a], "terc4");
        end
        drive(0, 1, 2'b00, 8'h00); expect_at(2, 10'b0100000000, "after_island");
`endif

        for (int i = 0; i < 4; i++) drive(0, 0, 2'b00, 8'h00);
        @(negedge clkin);
        @(posedge clkin);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
